spi_txn_ctrl: RTL and testbench
===============================

SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

Interface
REQ-001 Parameter DSIZE, default 8: byte width of the FIFO read data and the shifter data.
REQ-002 Parameter LEN_W, default 5: width of the transaction length field, so the maximum length is 31 bytes.
REQ-003 Parameter CS_SETUP, default 2: number of cycles spi_cs is high before the first tx_start.
REQ-004 Parameter CS_HOLD, default 2: number of cycles spi_cs stays high after the last tx_done.
REQ-005 Parameter STALL_MAX, default 16: number of consecutive fifo_empty cycles in FETCH that causes an underrun abort.
REQ-006 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 cmd_valid  input  1  transaction request.
REQ-009 cmd_len  input  LEN_W  number of bytes in the requested transaction.
REQ-010 cmd_ready  output  1  high only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-011 fifo_empty  input  1  the source FIFO has no data.
REQ-012 fifo_rd_en  output  1  one-cycle pop strobe to the FIFO.
REQ-013 fifo_rdata  input  DSIZE  FIFO read data, valid the cycle after fifo_rd_en.
REQ-014 tx_start  output  1  one-cycle strobe telling the byte shifter to start.
REQ-015 tx_byte  output  DSIZE  byte to shift; held stable from tx_start until tx_done.
REQ-016 tx_done  input  1  one-cycle pulse from the shifter when the byte is complete.
REQ-017 spi_cs  output  1  chip select, active-high, matching the existing FIFO block's polarity.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when a transaction ends, whether it completes or aborts.
REQ-020 err_underrun  output  1  sticky flag; cleared when the next command is accepted.
REQ-021 bytes_sent  output  LEN_W  count of bytes completed in the current or last transaction.

Function
REQ-022 FSM states SHALL be IDLE, SETUP, FETCH, LOAD, SEND, HOLD.
REQ-023 IDLE: on accept, latch remaining=cmd_len and clear bytes_sent and err_underrun.
REQ-024 IDLE accept with cmd_len=0: stay in IDLE, pulse done the next cycle, and never assert spi_cs.
REQ-025 IDLE accept with cmd_len>0: go to SETUP the next cycle.
REQ-026 SETUP: spi_cs=1 for exactly CS_SETUP cycles, then go to FETCH.
REQ-027 FETCH with fifo_empty=0: assert fifo_rd_en for one cycle and go to LOAD.
REQ-028 FETCH with fifo_empty=1: hold in FETCH with spi_cs=1 and increment the stall counter.
REQ-029 FETCH stall counter: reset to 0 on each entry to FETCH.
REQ-030 FETCH underrun: when the stall counter reaches STALL_MAX, set err_underrun and go to HOLD.
REQ-031 LOAD: capture fifo_rdata into tx_byte, pulse tx_start for one cycle, and go to SEND.
REQ-032 The fifo_rd_en to tx_start latency SHALL be exactly 1 cycle.
REQ-033 SEND: wait for tx_done with no timeout.
REQ-034 SEND on tx_done: increment bytes_sent and decrement remaining.
REQ-035 SEND exit: if remaining becomes 0 go to HOLD, otherwise go to FETCH.
REQ-036 A tx_done arriving in the same cycle as tx_start SHALL be ignored.
REQ-037 tx_done outside SEND SHALL be ignored.
REQ-038 HOLD: spi_cs=1 for CS_HOLD cycles, then on the last HOLD cycle go to IDLE with spi_cs=0 and done=1.
REQ-039 The minimum CS-low gap between transactions SHALL be 1 cycle, because cmd_ready rises only in the IDLE cycle after HOLD.
REQ-040 spi_cs SHALL be registered and equal 1 exactly in SETUP, FETCH, LOAD, SEND and HOLD.
REQ-041 At most one fifo_rd_en SHALL be issued per byte; no pop is issued after remaining reaches 0 or after an abort.
REQ-042 Counters SHALL be unsigned, LEN_W bits for length and bytes_sent; no wrap is possible because bytes_sent ≤ cmd_len.
REQ-043 The stall and CS counters SHALL be sized to hold the maximum of STALL_MAX, CS_SETUP and CS_HOLD.
REQ-044 cmd_valid while busy SHALL be ignored; the command is not queued.

Reset
REQ-045 While rst=1 at a clk edge: state=IDLE, all counters=0, and tx_byte=0.
REQ-046 While rst=1 at a clk edge, every output is 0 except cmd_ready, which is 1.
REQ-047 Reset mid-transaction SHALL drop spi_cs on the next edge with no HOLD phase and no done pulse.
REQ-048 The first command SHALL be accepted in the first cycle after rst falls.

Structure
REQ-049 Package spi_pkg SHALL hold the FSM state encoding and the default DSIZE, LEN_W, CS_SETUP, CS_HOLD and STALL_MAX constants.
REQ-050 One sub-module spi_cs_timer SHALL provide a loadable down-counter with a zero flag, shared by SETUP, FETCH-stall and HOLD.
REQ-051 All other logic SHALL be flat in spi_txn_ctrl.

Verification
REQ-052 Command len=3 with FIFO holding A5,3C,FF and the shifter answering tx_done 8 cycles after each tx_start.
  Required: tx_byte sequence A5,3C,FF; spi_cs high from accept+1 to the last tx_done+2; done pulsed once; bytes_sent=3.
REQ-053 Command len=0.
  Required: done pulses 1 cycle later; spi_cs, fifo_rd_en and tx_start stay 0.
REQ-054 Command len=2 with FIFO holding 1 byte, then empty for 20 cycles.
  Required: one byte sent; err_underrun=1 after 16 stall cycles; HOLD then done; bytes_sent=1.
REQ-055 Command len=2 with the FIFO empty for 5 cycles before the second byte arrives.
  Required: no error; spi_cs stays high through the stall; bytes_sent=2.
REQ-056 rst asserted during the second SEND of a len=4 transfer.
  Required: spi_cs=0 and cmd_ready=1 next cycle; no done pulse; a new command is accepted right after reset.
REQ-057 cmd_valid held high continuously with len=1 and the FIFO always non-empty.
  Required: back-to-back transactions with exactly 1 cycle of spi_cs=0 between them; cmd_ready is never high while busy.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI transaction controller.
package spi_pkg;

  localparam int DSIZE_DEF     = 8;
  localparam int LEN_W_DEF     = 5;
  localparam int CS_SETUP_DEF  = 2;
  localparam int CS_HOLD_DEF   = 2;
  localparam int STALL_MAX_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Width of a counter able to hold the largest of the three timing constants.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter with zero flag; times CS setup, FIFO stall and CS hold.
module spi_cs_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: pops bytes from a FIFO, hands them to a byte
// shifter and frames the transfer with chip select setup/hold timing.
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int CS_SETUP  = CS_SETUP_DEF,
  parameter int CS_HOLD   = CS_HOLD_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             tx_start,
  output logic [DSIZE-1:0] tx_byte,
  input  logic             tx_done,
  output logic             spi_cs,
  output logic             busy,
  output logic             done,
  output logic             err_underrun,
  output logic [LEN_W-1:0] bytes_sent,
  output logic [2:0]       dbg_state
);

  // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so requests while busy are dropped.

  localparam int TW = tmr_width(STALL_MAX, CS_SETUP, CS_HOLD);
  // Loaded one below the cycle count: the zero cycle is the last one counted.
  localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] STALL_LD = TW'(STALL_MAX - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining, bytes_sent_q;
  logic [DSIZE-1:0] tx_byte_q;
  logic             err_q, done_q, cs_q;
  logic             accept, abort, finish;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]    tmr_val;

  assign accept = cmd_valid && (state == ST_IDLE);

  spi_cs_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    tx_start   = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:  if (accept && (cmd_len != '0)) state_next = ST_SETUP;
      ST_SETUP: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = ST_LOAD;
        end else if (tmr_zero) begin
          abort      = 1'b1;
          state_next = ST_HOLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        tx_start   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND:  if (tx_done) state_next = (remaining == LEN_W'(1)) ? ST_HOLD : ST_FETCH;
      ST_HOLD: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    // Every entry into a timed state restarts the shared timer.
    if (state_next != state) begin
      case (state_next)
        ST_SETUP: begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
        ST_FETCH: begin tmr_load = 1'b1; tmr_val = STALL_LD; end
        ST_HOLD:  begin tmr_load = 1'b1; tmr_val = HOLD_LD;  end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      bytes_sent_q <= '0;
      tx_byte_q    <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      cs_q         <= 1'b0;
    end else begin
      state  <= state_next;
      cs_q   <= (state_next != ST_IDLE);
      done_q <= finish || (accept && (cmd_len == '0));
      if (accept) begin
        remaining    <= cmd_len;
        bytes_sent_q <= '0;
        err_q        <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
      if (state == ST_LOAD) tx_byte_q <= fifo_rdata;
      if ((state == ST_SEND) && tx_done) begin
        bytes_sent_q <= bytes_sent_q + LEN_W'(1);
        remaining    <= remaining - LEN_W'(1);
      end
    end
  end

  // In LOAD the popped byte is passed straight through so it is already valid
  // alongside tx_start; the register then holds it until tx_done.
  assign tx_byte      = (state == ST_LOAD) ? fifo_rdata : tx_byte_q;
  assign cmd_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign spi_cs       = cs_q;
  assign done         = done_q;
  assign err_underrun = err_q;
  assign bytes_sent   = bytes_sent_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl with a FIFO model and an 8-cycle shifter model.
module tb_spi_txn_ctrl;

  localparam int DSIZE = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] fifo_rdata = '0;
  logic             tx_start;
  logic [DSIZE-1:0] tx_byte;
  logic             tx_done;
  logic             spi_cs, busy, done, err_underrun;
  logic [LEN_W-1:0] bytes_sent;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  spi_txn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rdata   (fifo_rdata),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_done      (tx_done),
    .spi_cs       (spi_cs),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun),
    .bytes_sent   (bytes_sent),
    .dbg_state    (dbg_state)
  );

  // FIFO model: data appears on fifo_rdata the cycle after the pop.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Shifter model: tx_done 8 cycles after tx_start; stray injects extra pulses.
  int   sh_cnt = 0;
  logic stray = 1'b0;
  always @(posedge clk) begin
    if (rst) sh_cnt <= 0;
    else if (tx_start) sh_cnt <= 8;
    else if (sh_cnt != 0) sh_cnt <= sh_cnt - 1;
  end
  assign tx_done = (sh_cnt == 1) || stray;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  logic [7:0] byte_log [0:63];
  int gap_log [0:31];
  int start_cnt = 0, done_cnt = 0, pop_cnt = 0, cs_rise_cnt = 0, gap_n = 0;
  int excl_viol = 0, unstable = 0;
  int cs_rise = 0, cs_last = 0, last_done = 0, acc_cyc = 0, done_cyc = 0;
  int err_rise = 0, low_start = 0;
  logic prev_cs = 1'b0, prev_err = 1'b0, have_low = 1'b0;
  logic [7:0] cur_byte = '0;

  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      byte_log[start_cnt] = tx_byte;
      start_cnt = start_cnt + 1;
      cur_byte = tx_byte;
    end
    if (tx_done && busy && !tx_start && (tx_byte != cur_byte)) unstable = unstable + 1;
    if (tx_done) last_done = cyc;
    if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (fifo_rd_en) pop_cnt = pop_cnt + 1;
    if (cmd_ready && busy) excl_viol = excl_viol + 1;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (err_underrun && !prev_err) err_rise = cyc;
    if (spi_cs && !prev_cs) begin
      cs_rise = cyc;
      cs_rise_cnt = cs_rise_cnt + 1;
      if (have_low) begin
        gap_log[gap_n] = cyc - low_start;
        gap_n = gap_n + 1;
      end
    end
    if (!spi_cs && prev_cs) begin
      low_start = cyc;
      have_low = 1'b1;
    end
    if (spi_cs) cs_last = cyc;
    prev_cs = spi_cs;
    prev_err = err_underrun;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic send_cmd(input int len, output int waits);
    waits = 0;
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(len);
    while (!cmd_ready && waits < 100) begin
      tick(1);
      waits = waits + 1;
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int w, d0, p0, s0, c0, g0, n;

  initial begin
    tick(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_spi_cs", 32'(spi_cs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_bytes_sent", 32'(bytes_sent), 32'd0);
    check("rst_err", 32'(err_underrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Three-byte transfer, accepted in the first cycle out of reset.
    push(8'hA5); push(8'h3C); push(8'hFF);
    d0 = done_cnt; p0 = pop_cnt; s0 = start_cnt;
    send_cmd(3, w);
    check("t1_first_accept", 32'(w), 32'd0);
    wait_done(300);
    check("t1_byte0", 32'(byte_log[s0]), 32'hA5);
    check("t1_byte1", 32'(byte_log[s0+1]), 32'h3C);
    check("t1_byte2", 32'(byte_log[s0+2]), 32'hFF);
    check("t1_cs_rise", 32'(cs_rise - acc_cyc), 32'd1);
    check("t1_cs_last", 32'(cs_last - last_done), 32'd2);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_pops", 32'(pop_cnt - p0), 32'd3);
    check("t1_bytes_sent", 32'(bytes_sent), 32'd3);
    check("t1_err", 32'(err_underrun), 32'd0);

    // Zero-length command.
    d0 = done_cnt; p0 = pop_cnt; s0 = start_cnt; c0 = cs_rise_cnt;
    send_cmd(0, w);
    check("t2_done_pulse", 32'(done), 32'd1);
    check("t2_cs", 32'(spi_cs), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    tick(1);
    check("t2_done_end", 32'(done), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_pops", 32'(pop_cnt - p0), 32'd0);
    check("t2_starts", 32'(start_cnt - s0), 32'd0);
    check("t2_cs_rises", 32'(cs_rise_cnt - c0), 32'd0);

    // Underrun: one byte available out of two.
    push(8'h5A);
    d0 = done_cnt; p0 = pop_cnt; s0 = start_cnt;
    send_cmd(2, w);
    wait_done(300);
    check("t3_starts", 32'(start_cnt - s0), 32'd1);
    check("t3_byte0", 32'(byte_log[s0]), 32'h5A);
    check("t3_err", 32'(err_underrun), 32'd1);
    check("t3_err_time", 32'(err_rise - last_done), 32'd17);
    check("t3_done_time", 32'(done_cyc - last_done), 32'd19);
    check("t3_bytes_sent", 32'(bytes_sent), 32'd1);
    check("t3_pops", 32'(pop_cnt - p0), 32'd1);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Five-cycle stall before the second byte.
    push(8'h11);
    d0 = done_cnt; s0 = start_cnt; c0 = cs_rise_cnt;
    send_cmd(2, w);
    check("t4_err_cleared", 32'(err_underrun), 32'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_done) begin n = 1; break; end
    end
    check("t4_first_done", 32'(n), 32'd1);
    @(posedge clk); #1;
    tick(5);
    push(8'h22);
    wait_done(300);
    check("t4_err", 32'(err_underrun), 32'd0);
    check("t4_bytes_sent", 32'(bytes_sent), 32'd2);
    check("t4_byte0", 32'(byte_log[s0]), 32'h11);
    check("t4_byte1", 32'(byte_log[s0+1]), 32'h22);
    check("t4_cs_rises", 32'(cs_rise_cnt - c0), 32'd1);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Stray tx_done while idle.
    d0 = done_cnt;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(1);
    check("t5_bytes_sent", 32'(bytes_sent), 32'd2);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Reset during the second SEND of a four-byte transfer.
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    d0 = done_cnt; s0 = start_cnt;
    send_cmd(4, w);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_start) n = n + 1;
      if (n == 2) break;
    end
    check("t6_second_start", 32'(n), 32'd2);
    @(posedge clk); #1;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("t6_cs", 32'(spi_cs), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_bytes_sent", 32'(bytes_sent), 32'd0);
    check("t6_tx_byte", 32'(tx_byte), 32'd0);
    rst = 1'b0;
    send_cmd(1, w);
    check("t6_accept_after_rst", 32'(w), 32'd0);
    wait_done(300);
    check("t6_byte", 32'(byte_log[s0+2]), 32'h33);
    check("t6_bytes_sent", 32'(bytes_sent), 32'd1);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Back-to-back single-byte commands with cmd_valid held high.
    push(8'h41); push(8'h42);
    d0 = done_cnt; s0 = start_cnt; g0 = gap_n;
    cmd_len = LEN_W'(1);
    cmd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) n = n + 1;
      if (n == 3) break;
    end
    cmd_valid = 1'b0;
    check("t7_dones_seen", 32'(n), 32'd3);
    tick(2);
    check("t7_starts", 32'(start_cnt - s0), 32'd3);
    check("t7_byte0", 32'(byte_log[s0]), 32'h34);
    check("t7_byte1", 32'(byte_log[s0+1]), 32'h41);
    check("t7_byte2", 32'(byte_log[s0+2]), 32'h42);
    check("t7_gap1", 32'(gap_log[g0+1]), 32'd1);
    check("t7_gap2", 32'(gap_log[g0+2]), 32'd1);
    check("t7_busy", 32'(busy), 32'd0);

    check("ready_busy_exclusive", 32'(excl_viol), 32'd0);
    check("tx_byte_stable", 32'(unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
